// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
// Purpose: multiply/divide op class constants and the md_sequencer state enum.
// Ports: none (package).
package pipeline_ctrl_pkg;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multiply/divide unit start/busy/done sequencer
// Purpose: starts the multiply/divide unit and tracks its busy time.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_md_op      EX multiply/divide class (00 none, 01 mult, 10 div, 11 none)
//   o_md_start   one-cycle start pulse
//   o_md_busy    unit occupied (includes the start cycle)
//   o_hilo_we    one-cycle HI/LO write strobe
module md_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_md_op,
  output logic       o_md_start,
  output logic       o_md_busy,
  output logic       o_hilo_we
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_md_start;

  // Start only from IDLE; a new op seen while occupied is ignored.
  // Gating with rst_n keeps md_start/md_busy low while reset is held.
  assign w_md_start = rst_n && (r_state == MD_IDLE) &&
                      ((i_md_op == MD_MULT) || (i_md_op == MD_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (w_md_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = (i_md_op == MD_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                             : CNT_W'(DIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        // cnt==0 is the last busy cycle; the counter never wraps.
        if (r_cnt == '0) w_state_nxt = MD_DONE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    o_md_start = w_md_start;
    o_md_busy  = (r_state != MD_IDLE) || w_md_start;
    o_hilo_we  = (r_state == MD_DONE);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / mul-div stall and branch flush control
// Purpose: stalls the front end on load-use and mul/div hazards, flushes on
//   taken branches, and hosts the multiply/divide sequencer.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   IF_ID_RS/RT, IF_ID_uses_RT ID source registers and RT-use flag
//   IF_ID_md_op, IF_ID_hilo_read ID is a mul/div op / MFHI-MFLO
//   ID_EX_MemRead, ID_EX_dest_reg, ID_EX_md_op  EX instruction info
//   branch_taken               EX resolved a taken branch/jump
//   PC_write, IF_ID_write      front-end load enables
//   IF_ID_flush, ID_EX_bubble  squash controls
//   md_start, md_busy, hilo_we mul/div sequencer outputs
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] IF_ID_RS,
  input  logic [4:0] IF_ID_RT,
  input  logic       IF_ID_uses_RT,
  input  logic       IF_ID_md_op,
  input  logic       IF_ID_hilo_read,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_dest_reg,
  input  logic [1:0] ID_EX_md_op,
  input  logic       branch_taken,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       md_start,
  output logic       md_busy,
  output logic       hilo_we
);

  logic w_load_use;
  logic w_md_hazard;
  logic w_stall;
  logic w_flush;

  md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_sequencer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_md_op    (ID_EX_md_op),
    .o_md_start (md_start),
    .o_md_busy  (md_busy),
    .o_hilo_we  (hilo_we)
  );

  // Register 0 is hardwired zero, so a load into it never creates a dependency.
  assign w_load_use  = ID_EX_MemRead && (ID_EX_dest_reg != 5'd0) &&
                       ((ID_EX_dest_reg == IF_ID_RS) ||
                        (IF_ID_uses_RT && (ID_EX_dest_reg == IF_ID_RT)));
  assign w_md_hazard = md_busy && (IF_ID_md_op || IF_ID_hilo_read);

  // A taken branch squashes the ID instruction, so its stall is moot and the
  // PC must be free to load the target. rst_n gating keeps reset outputs idle.
  assign w_flush = rst_n && branch_taken;
  assign w_stall = rst_n && (w_load_use || w_md_hazard) && !branch_taken;

  assign IF_ID_flush  = w_flush;
  assign ID_EX_bubble = w_flush || w_stall;
  assign PC_write     = !w_stall;
  assign IF_ID_write  = !w_stall;

endmodule
